// File: rtl/host_comm.sv
// host_comm
// ---------
// Host-side end of the logic analyzer's command link. A two-byte command
// sequencer feeds an 8N1 transmitter that serializes a 16-bit command
// (high byte first) onto TX. An independent 8N1 receiver deserializes
// response bytes arriving on RX. Transmitter and receiver run concurrently.
//
// Parameters:
//   BAUD_DIV      clk cycles per UART bit (16..4095)
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   cmd           16-bit command, sent as cmd[15:8] then cmd[7:0]
//   snd_cmd       one-cycle send request, honoured only while idle
//   cmd_cmplt     set when both bytes have left the line, held until next send
//   TX            serial out, idles high
//   RX            asynchronous serial in
//   resp          last correctly framed response byte
//   resp_rdy      resp holds a new byte
//   clr_resp_rdy  one-cycle clear of resp_rdy
module host_comm #(
  parameter int BAUD_DIV = 108
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_cmplt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

  // ---------------- transmitter ----------------
  tx_state_t   tx_state, tx_next;
  logic [15:0] cmd_hold;
  logic [9:0]  tx_shift;
  logic [11:0] tx_baud;
  logic [3:0]  tx_bit;
  logic        tx_start;
  logic        accept;
  logic        stop_end;

  assign accept   = (tx_state == TX_IDLE) && snd_cmd;
  // tx_start marks the single cycle between acceptance and the start bit,
  // so the start bit appears one edge after snd_cmd is sampled.
  assign stop_end = !tx_start && (tx_baud == 12'd0) && (tx_bit == 4'd9);
  assign TX       = tx_shift[0];

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (snd_cmd)  tx_next = TX_HIGH;
      TX_HIGH: if (stop_end) tx_next = TX_LOW;
      TX_LOW:  if (stop_end) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_hold  <= 16'h0000;
      tx_shift  <= '1;
      tx_baud   <= 12'd0;
      tx_bit    <= 4'd0;
      tx_start  <= 1'b0;
      cmd_cmplt <= 1'b0;
    end else if (accept) begin
      cmd_hold  <= cmd;
      tx_start  <= 1'b1;
      tx_baud   <= 12'd0;
      tx_bit    <= 4'd0;
      cmd_cmplt <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      if (tx_start) begin
        tx_shift <= {1'b1, cmd_hold[15:8], 1'b0};
        tx_baud  <= BAUD_LAST;
        tx_bit   <= 4'd0;
        tx_start <= 1'b0;
      end else if (tx_baud != 12'd0) begin
        tx_baud <= tx_baud - 12'd1;
      end else if (tx_bit != 4'd9) begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bit   <= tx_bit + 4'd1;
        tx_baud  <= BAUD_LAST;
      end else if (tx_state == TX_HIGH) begin
        // second frame starts on the same edge the first stop bit ends
        tx_shift <= {1'b1, cmd_hold[7:0], 1'b0};
        tx_bit   <= 4'd0;
        tx_baud  <= BAUD_LAST;
      end else begin
        tx_shift  <= '1;
        cmd_cmplt <= 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t   rx_state, rx_next;
  logic        rx_meta, rx_sync;
  logic [11:0] rx_baud;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        sample;
  logic        byte_done;

  assign sample    = (rx_state == RX_RECV) && (rx_baud == 12'd0);
  assign byte_done = sample && (rx_bit == 4'd9) && rx_sync;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (!rx_sync) rx_next = RX_RECV;
      // leave on a start bit that reads high mid-bit (glitch) or at the stop sample
      RX_RECV: if (sample && (((rx_bit == 4'd0) && rx_sync) || (rx_bit == 4'd9)))
                 rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_baud  <= 12'd0;
      rx_bit   <= 4'd0;
      rx_shift <= 8'h00;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      if (rx_state == RX_IDLE) begin
        rx_baud <= HALF_LAST;
        rx_bit  <= 4'd0;
      end else if (rx_baud != 12'd0) begin
        rx_baud <= rx_baud - 12'd1;
      end else begin
        rx_baud <= BAUD_LAST;
        rx_bit  <= rx_bit + 4'd1;
        if ((rx_bit != 4'd0) && (rx_bit != 4'd9))
          rx_shift <= {rx_sync, rx_shift[7:1]};
      end
      if (byte_done) resp <= rx_shift;
      // a completing byte takes priority over any clear in the same cycle
      if (byte_done)                   resp_rdy <= 1'b1;
      else if (clr_resp_rdy || accept) resp_rdy <= 1'b0;
    end
  end

endmodule

// File: doc/host_comm.md
# host_comm

Host-side end of the logic analyzer's command link: serializes a 16-bit command onto the UART line into the analyzer's RX pin and deserializes the 8-bit response byte coming back from its TX pin. It is used as the bench/host stand-in and as the on-board loopback master for link self-test. Internally it contains an 8N1 transmitter with a two-byte command sequencer, and an independent 8N1 receiver.

## Interface
- BAUD_DIV, 108: clk cycles per UART bit; legal range 16..4095.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous and active-high; one clock domain, `clk`.
- cmd  input  16  command to send; byte order on the line is cmd[15:8], then cmd[7:0].
- snd_cmd  input  1  one-cycle request to send `cmd`; honoured only when the sequencer is idle.
- cmd_cmplt  output  1  high once both bytes are fully transmitted; held until the next accepted snd_cmd or reset.
- TX  output  1  serial out to the analyzer RX; idles high.
- RX  input  1  serial in from the analyzer TX; asynchronous.
- resp  output  8  last correctly framed response byte.
- resp_rdy  output  1  high when `resp` holds a new byte.
- clr_resp_rdy  input  1  one-cycle clear of resp_rdy.

## Operation
- Transmit sequencer states: IDLE, HIGH, LOW.
  - IDLE -> HIGH on snd_cmd: latch cmd into a 16-bit holding register and clear cmd_cmplt.
  - HIGH -> LOW when the stop bit of byte 1 ends.
  - LOW -> IDLE when the stop bit of byte 2 ends; set cmd_cmplt.
- snd_cmd in HIGH or LOW is ignored. cmd changes after acceptance have no effect.
- Tx frame: start bit (0), data bits 0..7 with LSB first, stop bit (1). Each bit lasts exactly BAUD_DIV cycles.
- Tx counters:
  - baud counter, 12 bits, reloaded at every bit boundary.
  - bit counter, 4 bits, counts 0..9.
  - 10-bit shift register, shifted right, with TX driven from its LSB.
- No idle gap between byte 1's stop bit and byte 2's start bit.
- Receiver states: IDLE, RECV.
  - RX passes through a 2-flop synchronizer, reset value 1.
  - IDLE -> RECV when the synchronized RX is 0.
  - First sample point is BAUD_DIV/2 cycles later (integer divide). The start bit is re-checked there: if it reads 1, treat it as a glitch and return to IDLE with no output.
  - Subsequent sample points are every BAUD_DIV cycles: 8 data bits, LSB first, then the stop bit.
  - Stop bit = 1: load resp and set resp_rdy.
  - Stop bit = 0: framing error; discard the byte, leave resp and resp_rdy unchanged.
  - Either way, return to IDLE at that stop-bit sample point.
- resp_rdy is cleared by clr_resp_rdy or by an accepted snd_cmd.
- If a byte completes in the same cycle as a clear, the set wins.
- A new byte overwrites resp even if resp_rdy is still high; there is no overrun flag.
- Transmitter and receiver run concurrently and are fully independent. Full-duplex traffic is legal.

## Timing
- Reset values (synchronous): TX=1, cmd_cmplt=0, resp=8'h00, resp_rdy=0, both FSMs in IDLE, synchronizer flops=1.
- Reset mid-frame aborts immediately. TX returns high on the next edge and the partial frame is lost.
- snd_cmd is sampled at edge N. TX falls (start bit) at edge N+1.
- cmd_cmplt rises at edge N+1+20*BAUD_DIV, coincident with TX finishing the last stop bit. TX is already 1 at that point.
- snd_cmd in the same cycle that cmd_cmplt rises is ignored, because the sequencer is not yet IDLE.
- snd_cmd one cycle later is accepted. cmd_cmplt falls on that edge.
- Rx latency: falling edge of RX to resp_rdy is 2 sync cycles + BAUD_DIV/2 + 9*BAUD_DIV cycles, ±1 cycle. resp_rdy rises at the middle of the stop bit.
- Rx tolerates ±3% baud mismatch.
- clr_resp_rdy takes effect on the next edge.

## Test plan
- Loopback: TX tied to RX, BAUD_DIV=16, cmd=16'hA55A, pulse snd_cmd.
  - resp=8'hA5 with resp_rdy.
  - clr_resp_rdy, then resp=8'h5A with resp_rdy.
  - cmd_cmplt exactly 320 cycles after the cycle following snd_cmd.
- TX waveform check, BAUD_DIV=16, cmd=16'h0180.
  - TX bit sequence: 0,1,0000000,1 | 0,0000000,1,1, each bit 16 cycles wide.
  - No gap between bytes.
- Busy rejection: second snd_cmd with cmd=16'hFFFF issued during byte 1. The line still carries the original command and cmd_cmplt pulses once.
- Framing error: drive RX with byte 8'h3C and stop bit 0.
  - resp_rdy stays 0 and resp is unchanged.
  - A following valid byte 8'hC3 gives resp=8'hC3 with resp_rdy=1.
- Glitch and clear/set collision:
  - A 3-cycle low pulse on RX produces no resp_rdy.
  - clr_resp_rdy asserted on the cycle a byte completes leaves resp_rdy=1.
- Reset mid-transmit: assert rst halfway through byte 2.
  - Next edge: TX=1, cmd_cmplt=0, resp_rdy=0.
  - A new snd_cmd afterward transmits normally.
